// File: rtl/rnd_harvest_ctrl.sv
// -----------------------------------------------------------------------------
// rnd_harvest_ctrl
//
// Sequencer and packer for a bank of gated entropy cells. One cell at a time
// is gated, round-robin. After the gate has been high for SETTLE cycles the
// cell's raw bit is sampled. Sampled bits are packed MSB-first into OUT_W-bit
// words, and each word is offered on a valid/ready port. A repetition-count
// health test watches every raw bit. When it trips, harvesting stops until
// reset.
//
// Optional feature (macro VON_NEUMANN_EN):
//   When defined, consecutive samples are debiased in pairs: 01 packs 0,
//   10 packs 1, and 00/11 pack nothing. When undefined, every sample is packed
//   directly and no pair logic exists.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   en_i           harvest enable
//   src_gate_o     one-hot gate drive, bit k gates cell k
//   src_bit_i      raw bits, bit k from cell k
//   cur_src_o      index of the cell being gated (or next to be gated)
//   out_data_o     packed output word
//   out_valid_o    out_data_o holds a word waiting for the consumer
//   out_ready_i    consumer accepts the word
//   health_fail_o  sticky repetition-count failure
// -----------------------------------------------------------------------------
module rnd_harvest_ctrl #(
  parameter int N_SRC     = 16,
  parameter int SETTLE    = 4,
  parameter int OUT_W     = 8,
  parameter int REP_LIMIT = 32,
  localparam int IdxW     = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [N_SRC-1:0] src_gate_o,
  input  logic [N_SRC-1:0] src_bit_i,
  output logic [IdxW-1:0]  cur_src_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             health_fail_o
);

  localparam int SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BitW = $clog2(OUT_W + 1);
  localparam int RepW = $clog2(REP_LIMIT + 1);
  localparam logic [N_SRC-1:0] GateOne = N_SRC'(1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    SAMPLE,
    OUT
  } state_e;

  state_e           state_q, state_d;
  logic [SetW-1:0]  settleCnt_q, settleCnt_d;
  logic [IdxW-1:0]  curSrc_q, curSrc_d;
  logic [BitW-1:0]  bitCnt_q, bitCnt_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0] outData_q, outData_d;
  logic [RepW-1:0]  repCnt_q, repCnt_d;
  logic             prevBit_q, prevBit_d;
  logic             healthFail_q, healthFail_d;
`ifdef VON_NEUMANN_EN
  logic             pairHave_q, pairHave_d;
  logic             pairFirst_q, pairFirst_d;
`endif

  logic             sampledBit;
  logic [RepW-1:0]  repNext;
  logic             packValid;
  logic             packBit;

  // State register and all datapath registers. Reset is synchronous and wins
  // over everything, including a word pending in OUT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      settleCnt_q  <= '0;
      curSrc_q     <= '0;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      outData_q    <= '0;
      repCnt_q     <= '0;
      prevBit_q    <= 1'b0;
      healthFail_q <= 1'b0;
`ifdef VON_NEUMANN_EN
      pairHave_q   <= 1'b0;
      pairFirst_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      settleCnt_q  <= settleCnt_d;
      curSrc_q     <= curSrc_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      outData_q    <= outData_d;
      repCnt_q     <= repCnt_d;
      prevBit_q    <= prevBit_d;
      healthFail_q <= healthFail_d;
`ifdef VON_NEUMANN_EN
      pairHave_q   <= pairHave_d;
      pairFirst_q  <= pairFirst_d;
`endif
    end
  end

  // Next-state and datapath update logic. Only SAMPLE consumes a raw bit.
  // Everything else either counts settle time, waits for enable, or waits
  // for the consumer.
  always_comb begin
    state_d      = state_q;
    settleCnt_d  = settleCnt_q;
    curSrc_d     = curSrc_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    outData_d    = outData_q;
    repCnt_d     = repCnt_q;
    prevBit_d    = prevBit_q;
    healthFail_d = healthFail_q;
`ifdef VON_NEUMANN_EN
    pairHave_d   = pairHave_q;
    pairFirst_d  = pairFirst_q;
`endif

    sampledBit = src_bit_i[curSrc_q];
    // A zero count means no raw bit has been seen since reset, so the
    // first sample always starts a fresh run.
    repNext = (repCnt_q != '0 && sampledBit == prevBit_q) ? repCnt_q + RepW'(1) : RepW'(1);

`ifdef VON_NEUMANN_EN
    // Only the second bit of a differing pair yields output, and the
    // emitted value is the first bit of the pair.
    packValid = pairHave_q && (pairFirst_q != sampledBit);
    packBit   = pairFirst_q;
`else
    packValid = 1'b1;
    packBit   = sampledBit;
`endif

    case (state_q)
      IDLE: begin
        settleCnt_d = '0;
        if (en_i && !healthFail_q) begin
          state_d = GATE;
        end
      end
      GATE: begin
        // Dropping enable abandons the settle time of the current cell.
        // The partial word is kept.
        if (!en_i) begin
          state_d     = IDLE;
          settleCnt_d = '0;
        end else if (settleCnt_q == SetW'(SETTLE - 1)) begin
          state_d     = SAMPLE;
          settleCnt_d = '0;
        end else begin
          settleCnt_d = settleCnt_q + SetW'(1);
        end
      end
      SAMPLE: begin
        curSrc_d  = (curSrc_q == IdxW'(N_SRC - 1)) ? '0 : curSrc_q + IdxW'(1);
        repCnt_d  = repNext;
        prevBit_d = sampledBit;
        if (repNext == RepW'(REP_LIMIT)) begin
          healthFail_d = 1'b1;
          bitCnt_d     = '0;
          shift_d      = '0;
          state_d      = IDLE;
        end else begin
`ifdef VON_NEUMANN_EN
          pairHave_d  = !pairHave_q;
          pairFirst_d = pairHave_q ? pairFirst_q : sampledBit;
`endif
          if (packValid) begin
            shift_d  = {shift_q[OUT_W-2:0], packBit};
            bitCnt_d = bitCnt_q + BitW'(1);
          end
          if (packValid && bitCnt_q == BitW'(OUT_W - 1)) begin
            outData_d = {shift_q[OUT_W-2:0], packBit};
            bitCnt_d  = '0;
            state_d   = OUT;
          end else begin
            state_d = en_i ? GATE : IDLE;
          end
        end
      end
      OUT: begin
        // The word stays pending regardless of enable; only the handshake
        // releases it.
        if (out_ready_i) begin
          state_d = en_i ? GATE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef VON_NEUMANN_EN
    // A half-collected pair never survives a trip through IDLE.
    if (state_d == IDLE) begin
      pairHave_d = 1'b0;
    end
`endif
  end

  // Output decode. The gate stays high through SAMPLE so the cell is still
  // driven while its bit is captured.
  always_comb begin
    src_gate_o = '0;
    if (state_q == GATE || state_q == SAMPLE) begin
      src_gate_o = GateOne << curSrc_q;
    end
    cur_src_o     = curSrc_q;
    out_data_o    = outData_q;
    out_valid_o   = (state_q == OUT);
    health_fail_o = healthFail_q;
  end

endmodule
